rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4, number of sequenced reset output channels (1..16).
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, reset-deassert synchronizer depth (>=2).
REQ-003 SHALL provide parameter DELAY_W, default 8, width of the gap counter.
REQ-004 SHALL provide parameter GAP, default 16, cycles between successive channel releases (1..2^DELAY_W-1).
REQ-005 SHALL provide parameter ASSERT_CYC, default 8, minimum software-reset assertion length in cycles (1..2^DELAY_W-1).
REQ-006 SHALL provide clk  input  1  clock; all logic on rising edge.
REQ-007 SHALL provide rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL provide sw_rst_req  input  1  synchronous software reset request, level sampled each edge.
REQ-009 SHALL provide hold  input  1  freezes the release sequence while high.
REQ-010 SHALL provide rst_out_n  output  NUM_CH  per-channel active-low reset, registered.
REQ-011 SHALL provide rel_cnt  output  clog2(NUM_CH+1)  number of channels currently released.
REQ-012 SHALL provide seq_done  output  1  high when all channels are released.
REQ-013 SHALL provide busy  output  1  high whenever state is not DONE.

Function
REQ-014 SHALL implement states SYNC, WAIT, ASSERT, DONE.
REQ-015 SHALL, in SYNC, shift a 1 through a SYNC_STAGES-flop chain each edge; at edge SYNC_STAGES after rst_n rises, enter WAIT with gap counter 0 and channel index 0.
REQ-016 SHALL, in WAIT with hold=0, increment the gap counter each edge; on the edge where counter equals GAP-1, set rst_out_n[idx]=1, increment idx and rel_cnt, and clear the counter.
REQ-017 SHALL release channels strictly in order 0,1,...,NUM_CH-1; a released channel stays high until a reset event.
REQ-018 SHALL, in WAIT with hold=1, freeze the counter and idx; release resumes from the frozen count when hold falls.
REQ-019 SHALL enter DONE and set seq_done=1, busy=0 on the same edge that releases channel NUM_CH-1.
REQ-020 SHALL, on any edge with sw_rst_req=1 in WAIT or DONE, drive all rst_out_n=0, rel_cnt=0, seq_done=0, busy=1, clear the counter, and enter ASSERT.
REQ-021 SHALL remain in ASSERT for ASSERT_CYC edges counted from entry, then enter WAIT with counter 0 and idx 0.
REQ-022 SHALL restart the ASSERT count at 0 on any edge with sw_rst_req=1 while in ASSERT.
REQ-023 SHALL give sw_rst_req priority over a channel release on the same edge; that channel is not released.
REQ-024 SHALL ignore hold in SYNC, ASSERT and DONE, and ignore sw_rst_req in SYNC.
REQ-025 SHALL keep counter arithmetic modulo 2^DELAY_W with no wrap observable for legal GAP/ASSERT_CYC.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force rst_out_n=0, rel_cnt=0, seq_done=0, busy=1, synchronizer chain=0, counter=0, state SYNC.
REQ-027 SHALL deassert reset outputs only synchronously to clk via the synchronizer; rst_n low mid-sequence or in DONE SHALL immediately reassert all channels.

Verification
REQ-028 Defaults, rst_n rises before edge 1 -> rst_out_n bits 0..3 go high at edges 18, 34, 50, 66; seq_done=1, busy=0 at edge 66; rel_cnt steps 1..4.
REQ-029 Defaults, hold=1 for edges 20..29 -> ch0 at 18, ch1 at 44, ch3 and seq_done at 76.
REQ-030 In DONE, sw_rst_req pulse at edge T -> rst_out_n=4'b0000 at T, WAIT at T+8, ch0 high at T+24, seq_done at T+72.
REQ-031 sw_rst_req at edge 34 (ch1 release edge) -> ch1 not released, all channels 0, ch0 re-released at edge 58.
REQ-032 rst_n pulsed low asynchronously at mid-cycle during WAIT at rel_cnt=2 -> rst_out_n=0 before next edge, sequence restarts from SYNC.
REQ-033 NUM_CH=1, GAP=1, SYNC_STAGES=3 -> ch0 and seq_done high at edge 4.

Source files
------------

// File: rtl/rst_seq.sv
// rst_seq: power-on / software reset sequencer.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - async active-low reset
//   sw_rst_req - software reset request (level)
//   hold       - freezes channel release
//   rst_out_n  - per-channel active-low resets
//   rel_cnt    - channels currently released
//   seq_done   - all channels released
//   busy       - sequencer not finished
module rst_seq #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DELAY_W     = 8,
    parameter int GAP         = 16,
    parameter int ASSERT_CYC  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sw_rst_req,
    input  logic                          hold,
    output logic [NUM_CH-1:0]             rst_out_n,
    output logic [$clog2(NUM_CH+1)-1:0]   rel_cnt,
    output logic                          seq_done,
    output logic                          busy
);

    localparam int CW = $clog2(NUM_CH + 1);

    localparam logic [DELAY_W-1:0] GAP_M1 = DELAY_W'(GAP - 1);
    localparam logic [DELAY_W-1:0] ASC_M1 = DELAY_W'(ASSERT_CYC - 1);
    localparam logic [CW-1:0]      LAST   = CW'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_SYNC,
        S_WAIT,
        S_ASSERT,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] w_sync_nxt;
    logic [DELAY_W-1:0]     r_cnt;
    logic [DELAY_W-1:0]     w_cnt_nxt;
    logic [CW-1:0]          r_idx;
    logic [CW-1:0]          w_idx_nxt;
    logic [NUM_CH-1:0]      r_rst_n;
    logic [NUM_CH-1:0]      w_rst_n_nxt;
    logic [NUM_CH-1:0]      w_rel_mask;

    assign w_rel_mask = NUM_CH'(1) << r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_SYNC;
            r_sync  <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst_n <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sync  <= w_sync_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_rst_n <= w_rst_n_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sync_nxt  = {r_sync[SYNC_STAGES-2:0], 1'b1};
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_rst_n_nxt = r_rst_n;
        unique case (r_state)
            S_SYNC: begin
                // leave on the edge the last sync flop first goes high
                if (w_sync_nxt[SYNC_STAGES-1] && !r_sync[SYNC_STAGES-1]) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            S_WAIT: begin
                if (sw_rst_req) begin
                    // request wins over a release on the same edge
                    w_state_nxt = S_ASSERT;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_rst_n_nxt = '0;
                end else if (!hold) begin
                    if (r_cnt == GAP_M1) begin
                        w_rst_n_nxt = r_rst_n | w_rel_mask;
                        w_idx_nxt   = r_idx + CW'(1);
                        w_cnt_nxt   = '0;
                        if (r_idx == LAST) begin
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + DELAY_W'(1);
                    end
                end
            end
            S_ASSERT: begin
                if (sw_rst_req) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == ASC_M1) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + DELAY_W'(1);
                end
            end
            S_DONE: begin
                if (sw_rst_req) begin
                    w_state_nxt = S_ASSERT;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_rst_n_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_SYNC;
            end
        endcase
    end

    assign rst_out_n = r_rst_n;
    assign rel_cnt   = r_idx;
    assign seq_done  = (r_state == S_DONE);
    assign busy      = (r_state != S_DONE);

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed self-checking bench for rst_seq.
// Default instance plus a NUM_CH=1/GAP=1/SYNC_STAGES=3 instance.
module tb_rst_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] rst_out_n;
    logic [2:0] rel_cnt;
    logic       seq_done;
    logic       busy;
    logic [0:0] s_rst_out_n;
    logic [0:0] s_rel_cnt;
    logic       s_seq_done;
    logic       s_busy;

    int checks = 0;
    int failures = 0;
    int ecnt = 0;

    rst_seq u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_rst_req (sw_rst_req),
        .hold       (hold),
        .rst_out_n  (rst_out_n),
        .rel_cnt    (rel_cnt),
        .seq_done   (seq_done),
        .busy       (busy)
    );

    rst_seq #(
        .NUM_CH      (1),
        .GAP         (1),
        .SYNC_STAGES (3)
    ) u_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_rst_req (sw_rst_req),
        .hold       (hold),
        .rst_out_n  (s_rst_out_n),
        .rel_cnt    (s_rel_cnt),
        .seq_done   (s_seq_done),
        .busy       (s_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        sw_rst_req = 1'b0;
        hold       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ecnt  = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({rst_out_n, rel_cnt, seq_done, busy} !== {4'b0000, 3'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset got %b/%0d/%b/%b want 0000/0/0/1", rst_out_n, rel_cnt, seq_done, busy);
        end
        checks++;
        if ({s_rst_out_n, s_rel_cnt, s_seq_done, s_busy} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_small got %b%b%b%b want 0001", s_rst_out_n, s_rel_cnt, s_seq_done, s_busy);
        end
    endtask

    // Release edges 18,34,50,66; sw_rst_req high in SYNC is ignored.
    task automatic test_sequence();
        int rel[4] = '{18, 34, 50, 66};
        logic [3:0] exp_v;
        int exp_c;
        do_reset();
        sw_rst_req = 1'b1;
        for (int e = 1; e <= 70; e++) begin
            step();
            if (ecnt == 2) sw_rst_req = 1'b0;
            exp_c = 0;
            for (int i = 0; i < 4; i++) begin
                exp_v[i] = (ecnt >= rel[i]);
                if (ecnt >= rel[i]) exp_c++;
            end
            checks++;
            if (rst_out_n !== exp_v || rel_cnt !== 3'(exp_c)) begin
                failures++;
                $display("FAIL seq e=%0d got %b/%0d want %b/%0d", ecnt, rst_out_n, rel_cnt, exp_v, exp_c);
            end
            checks++;
            if (seq_done !== (ecnt >= 66) || busy !== (ecnt < 66)) begin
                failures++;
                $display("FAIL seq_done e=%0d got done=%b busy=%b", ecnt, seq_done, busy);
            end
        end
    endtask

    // hold high for edges 20..29 shifts later releases by 10.
    task automatic test_hold();
        int rel[4] = '{18, 44, 60, 76};
        logic [3:0] exp_v;
        do_reset();
        for (int e = 1; e <= 80; e++) begin
            step();
            if (ecnt == 19) hold = 1'b1;
            if (ecnt == 29) hold = 1'b0;
            for (int i = 0; i < 4; i++) exp_v[i] = (ecnt >= rel[i]);
            checks++;
            if (rst_out_n !== exp_v || seq_done !== (ecnt >= 76)) begin
                failures++;
                $display("FAIL hold e=%0d got %b/%b want %b/%b", ecnt, rst_out_n, seq_done, exp_v, (ecnt >= 76));
            end
        end
    endtask

    // From DONE: pulse at T -> ch0 at T+24, done at T+72.
    task automatic test_sw_rst_done();
        int rel[4] = '{24, 40, 56, 72};
        logic [3:0] exp_v;
        int t0;
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        t0 = ecnt;
        checks++;
        if ({rst_out_n, rel_cnt, seq_done, busy} !== {4'b0000, 3'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL swrst_at_T got %b/%0d/%b/%b want 0000/0/0/1", rst_out_n, rel_cnt, seq_done, busy);
        end
        for (int k = 1; k <= 72; k++) begin
            step();
            for (int i = 0; i < 4; i++) exp_v[i] = (k >= rel[i]);
            checks++;
            if (rst_out_n !== exp_v || busy !== (k < 72)) begin
                failures++;
                $display("FAIL swrst k=%0d got %b/%b want %b/%b", ecnt - t0, rst_out_n, busy, exp_v, (k < 72));
            end
        end
        checks++;
        if (seq_done !== 1'b1 || rel_cnt !== 3'd4) begin
            failures++;
            $display("FAIL swrst_done got %b/%0d want 1/4", seq_done, rel_cnt);
        end
    endtask

    // Second request at T+3 restarts ASSERT: ch0 at T+27; hold ignored.
    task automatic test_assert_restart();
        int t0;
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        t0 = ecnt;
        step();
        step();
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        hold = 1'b1;
        for (int k = 4; k <= 28; k++) begin
            step();
            if (ecnt - t0 == 8) hold = 1'b0;
            checks++;
            if (rst_out_n !== ((k >= 27) ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("FAIL restart k=%0d got %b want %b", k, rst_out_n, (k >= 27) ? 4'b0001 : 4'b0000);
            end
        end
    endtask

    // Request on ch1 release edge 34 cancels it; ch0 again at 58.
    task automatic test_back_to_back();
        do_reset();
        while (ecnt < 33) step();
        checks++;
        if (rst_out_n !== 4'b0001) begin
            failures++;
            $display("FAIL prio_pre got %b want 0001", rst_out_n);
        end
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        checks++;
        if (rst_out_n !== 4'b0000 || rel_cnt !== 3'd0) begin
            failures++;
            $display("FAIL prio_34 got %b/%0d want 0000/0", rst_out_n, rel_cnt);
        end
        while (ecnt < 58) begin
            step();
            checks++;
            if (rst_out_n !== ((ecnt >= 58) ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("FAIL prio e=%0d got %b want %b", ecnt, rst_out_n, (ecnt >= 58) ? 4'b0001 : 4'b0000);
            end
        end
    endtask

    // Async low pulse mid-cycle at rel_cnt=2, then full restart.
    task automatic test_async_reset();
        do_reset();
        while (ecnt < 40) step();
        checks++;
        if (rel_cnt !== 3'd2 || rst_out_n !== 4'b0011) begin
            failures++;
            $display("FAIL async_pre got %b/%0d want 0011/2", rst_out_n, rel_cnt);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rst_out_n, rel_cnt, seq_done, busy} !== {4'b0000, 3'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL async_low got %b/%0d/%b/%b want 0000/0/0/1", rst_out_n, rel_cnt, seq_done, busy);
        end
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        ecnt  = 0;
        while (ecnt < 18) begin
            step();
            if (ecnt >= 17) begin
                checks++;
                if (rst_out_n !== ((ecnt == 18) ? 4'b0001 : 4'b0000)) begin
                    failures++;
                    $display("FAIL async_restart e=%0d got %b", ecnt, rst_out_n);
                end
            end
        end
    endtask

    // NUM_CH=1, GAP=1, SYNC_STAGES=3: ch0 and done at edge 4.
    task automatic test_small();
        do_reset();
        for (int e = 1; e <= 5; e++) begin
            step();
            checks++;
            if (s_rst_out_n !== 1'(ecnt >= 4) || s_seq_done !== (ecnt >= 4) || s_busy !== (ecnt < 4)) begin
                failures++;
                $display("FAIL small e=%0d got %b/%b/%b", ecnt, s_rst_out_n, s_seq_done, s_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_hold();
        test_sw_rst_done();
        test_assert_restart();
        test_back_to_back();
        test_async_reset();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
